// File: rtl/aes_loader_pkg.sv
// Shared types for the AES block loader: byte/column/state types and the
// big-endian word-to-column split.
package aes_loader_pkg;

  localparam int NB = 4;

  typedef logic [7:0] byte_t;
  typedef byte_t [0:3] col_t;
  typedef col_t [0:NB-1] state_t;

  // Row r of a column is taken from in_word[31-8r -: 8].
  function automatic col_t word_to_col(input logic [31:0] w);
    col_t c;
    for (int r = 0; r < 4; r++) begin
      c[r] = w[31-8*r -: 8];
    end
    return c;
  endfunction

endpackage

// File: rtl/aes_col_accum.sv
// Four-column accumulator: column counter, column register, completion strobe.
// Clear resets only the counter; captured columns are left in place.
module aes_col_accum
  import aes_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        wr,
  input  logic [31:0] word,
  output state_t      cols,
  output logic [1:0]  cnt,
  output logic        done
);

  assign done = wr && !clr && (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      cols <= '0;
      cnt  <= 2'd0;
    end else if (clr) begin
      cnt <= 2'd0;
    end else if (wr) begin
      cols[cnt] <= word_to_col(word);
      cnt       <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/aes_block_loader.sv
// Assembles key and data words into AES state arrays and presents {data, key}
// blocks to the cipher core. Define AES_LOADER_DBUF_EN for the double-buffered build.
module aes_block_loader
  import aes_loader_pkg::*;
#(
  parameter bit KEY_PERSIST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [31:0] in_word,
  input  logic        in_key,
  input  logic        in_valid,
  output logic        in_ready,
  output state_t      out_data,
  output state_t      out_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_nokey
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and a presented block is held
  // unchanged until it transfers.

  logic       accept, key_wr, data_wr;
  logic       key_done, data_done, blk_ok;
  logic       key_ok;
  logic [1:0] kcnt, dcnt;
  state_t     key_cols, data_cols, key_active;
  logic       unused_kcnt;

  assign accept  = in_valid && in_ready && !clr;
  assign key_wr  = accept && in_key;
  assign data_wr = accept && !in_key;
  assign blk_ok  = data_done && key_ok;

  assign unused_kcnt = ^kcnt;

  aes_col_accum u_key_accum (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .wr   (key_wr),
    .word (in_word),
    .cols (key_cols),
    .cnt  (kcnt),
    .done (key_done)
  );

  aes_col_accum u_data_accum (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .wr   (data_wr),
    .word (in_word),
    .cols (data_cols),
    .cnt  (dcnt),
    .done (data_done)
  );

  // The completed key is frozen here so a partial reload cannot leak into a block.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_ok     <= 1'b0;
      key_active <= '0;
    end else if (clr) begin
      key_ok <= 1'b0;
    end else if (key_done) begin
      key_ok              <= 1'b1;
      key_active          <= key_cols;
      key_active[NB-1]    <= word_to_col(in_word);
    end else if (blk_ok && !KEY_PERSIST) begin
      key_ok <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      err_nokey <= 1'b0;
      out_key   <= '0;
    end else begin
      err_nokey <= data_done && !key_ok;
      if (blk_ok) begin
        out_valid <= 1'b1;
        out_key   <= key_active;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef AES_LOADER_DBUF_EN
  state_t out_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q <= '0;
    end else if (blk_ok) begin
      out_data_q       <= data_cols;
      out_data_q[NB-1] <= word_to_col(in_word);
    end
  end

  assign out_data = out_data_q;
  // Only the word that would complete a block must wait for the output slot.
  assign in_ready = !rst && !(dcnt == 2'd3 && out_valid && !out_ready);
`else
  logic unused_dcnt;

  assign unused_dcnt = ^dcnt;
  assign out_data    = data_cols;
  assign in_ready    = !rst && !out_valid;
`endif

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader; a second instance with KEY_PERSIST=0
// mirrors every accept of the main instance.
module tb_aes_block_loader;
  import aes_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [31:0] in_word = '0;
  logic        in_key = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, err_nokey;
  state_t      out_data, out_key;

  logic        np_in_valid, np_in_ready, np_out_valid, np_err_nokey;
  state_t      np_out_data, np_out_key;

  int checks = 0;
  int failures = 0;

  logic [31:0] key_w   [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
  logic [31:0] data_w  [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
  logic [31:0] fresh_w [4] = '{32'ha0a1a2a3, 32'hb0b1b2b3, 32'hc0c1c2c3, 32'hd0d1d2d3};

  always #5 clk = ~clk;

  aes_block_loader dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_word   (in_word),
    .in_key    (in_key),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_key   (out_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_nokey (err_nokey)
  );

  assign np_in_valid = in_valid && in_ready;

  aes_block_loader #(.KEY_PERSIST(1'b0)) dut_np (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_word   (in_word),
    .in_key    (in_key),
    .in_valid  (np_in_valid),
    .in_ready  (np_in_ready),
    .out_data  (np_out_data),
    .out_key   (np_out_key),
    .out_valid (np_out_valid),
    .out_ready (out_ready),
    .err_nokey (np_err_nokey)
  );

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  // Returns at #1 after the accepting edge.
  task automatic send_word(input logic k, input logic [31:0] w);
    int n = 0;
    in_key = k;
    in_word = w;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (err_nokey !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err_nokey); end
    checks++;
    if (out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++;
    if (out_key !== '0) begin failures++; $display("FAIL reset_out_key: got %h want 0", out_key); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_fips_block();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_word(1'b1, key_w[i]);
    for (int i = 0; i < 4; i++) send_word(1'b0, data_w[i]);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL fips_valid: got %b want 1", out_valid); end
    checks++;
    if (err_nokey !== 1'b0) begin failures++; $display("FAIL fips_err: got %b want 0", err_nokey); end
    checks++;
    if (out_data[0] !== 32'h00112233) begin failures++; $display("FAIL fips_data0: got %h want 00112233", out_data[0]); end
    checks++;
    if (out_data[3] !== 32'hccddeeff) begin failures++; $display("FAIL fips_data3: got %h want ccddeeff", out_data[3]); end
    checks++;
    if (out_key[3] !== 32'h0c0d0e0f) begin failures++; $display("FAIL fips_key3: got %h want 0c0d0e0f", out_key[3]); end
    checks++;
    if (out_key[0] !== 32'h00010203) begin failures++; $display("FAIL fips_key0: got %h want 00010203", out_key[0]); end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL fips_pulse_end: got %b want 0", out_valid); end
  endtask

  task automatic test_nokey();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_word(1'b0, data_w[i]);
    checks++;
    if (err_nokey !== 1'b1) begin failures++; $display("FAIL nokey_err: got %b want 1", err_nokey); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL nokey_valid: got %b want 0", out_valid); end
    @(posedge clk);
    #1;
    checks++;
    if (err_nokey !== 1'b0) begin failures++; $display("FAIL nokey_err_pulse: got %b want 0", err_nokey); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL nokey_valid_after: got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    int hold;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(1'b1, key_w[i]);
    for (int i = 0; i < 4; i++) send_word(1'b0, data_w[i]);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b want 1", out_valid); end
    hold = 10;
`ifdef AES_LOADER_DBUF_EN
    for (int i = 0; i < 3; i++) begin
      send_word(1'b0, fresh_w[i]);
      checks++;
      if (out_data[1] !== 32'h44556677) begin failures++; $display("FAIL stall_dbuf_data: got %h want 44556677", out_data[1]); end
    end
    hold = 7;
`endif
    in_key = 1'b0;
    in_word = 32'hdeadbeef;
    in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready: cycle %0d got %b want 0", i, in_ready); end
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_hold_valid: cycle %0d got %b want 1", i, out_valid); end
      checks++;
      if (out_data[1] !== 32'h44556677) begin failures++; $display("FAIL stall_data: cycle %0d got %h want 44556677", i, out_data[1]); end
      checks++;
      if (out_key[2] !== 32'h08090a0b) begin failures++; $display("FAIL stall_key: cycle %0d got %h want 08090a0b", i, out_key[2]); end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_release: got %b want 0", out_valid); end
  endtask

  task automatic test_interleave();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_word(1'b1, key_w[i]);
      send_word(1'b0, data_w[i]);
    end
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL inter_valid: got %b want 1", out_valid); end
    checks++;
    if (out_data[2] !== 32'h8899aabb) begin failures++; $display("FAIL inter_data2: got %h want 8899aabb", out_data[2]); end
    checks++;
    if (out_key[1] !== 32'h04050607) begin failures++; $display("FAIL inter_key1: got %h want 04050607", out_key[1]); end
    checks++;
    if (np_out_valid !== 1'b1) begin failures++; $display("FAIL inter_np_valid: got %b want 1", np_out_valid); end
    checks++;
    if (np_out_key[3] !== 32'h0c0d0e0f) begin failures++; $display("FAIL inter_np_key3: got %h want 0c0d0e0f", np_out_key[3]); end
    for (int i = 0; i < 4; i++) send_word(1'b0, data_w[i]);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL persist_valid: got %b want 1", out_valid); end
    checks++;
    if (err_nokey !== 1'b0) begin failures++; $display("FAIL persist_err: got %b want 0", err_nokey); end
    checks++;
    if (np_err_nokey !== 1'b1) begin failures++; $display("FAIL nopersist_err: got %b want 1", np_err_nokey); end
    checks++;
    if (np_out_valid !== 1'b0) begin failures++; $display("FAIL nopersist_valid: got %b want 0", np_out_valid); end
    checks++;
    if (np_in_ready !== 1'b1) begin failures++; $display("FAIL nopersist_ready: got %b want 1", np_in_ready); end
  endtask

  task automatic test_clr();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_word(1'b1, key_w[i]);
    send_word(1'b0, data_w[0]);
    send_word(1'b0, data_w[1]);
    clr = 1'b1;
    in_key = 1'b0;
    in_word = 32'hffffffff;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_word(1'b0, fresh_w[i]);
      checks++;
      if (err_nokey !== (i == 3)) begin failures++; $display("FAIL clr_err: word %0d got %b want %b", i, err_nokey, (i == 3)); end
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_valid: word %0d got %b want 0", i, out_valid); end
    end
    for (int i = 0; i < 4; i++) send_word(1'b1, key_w[i]);
    for (int i = 0; i < 4; i++) send_word(1'b0, fresh_w[i]);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL clr_reload_valid: got %b want 1", out_valid); end
    checks++;
    if (out_data[0] !== 32'ha0a1a2a3) begin failures++; $display("FAIL clr_data0: got %h want a0a1a2a3", out_data[0]); end
    checks++;
    if (out_data[3] !== 32'hd0d1d2d3) begin failures++; $display("FAIL clr_data3: got %h want d0d1d2d3", out_data[3]); end
  endtask

  task automatic test_reset_pending();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(1'b1, key_w[i]);
    for (int i = 0; i < 4; i++) send_word(1'b0, data_w[i]);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL rstp_pending: got %b want 1", out_valid); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rstp_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== '0) begin failures++; $display("FAIL rstp_data: got %h want 0", out_data); end
    checks++;
    if (out_key !== '0) begin failures++; $display("FAIL rstp_key: got %h want 0", out_key); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rstp_in_ready: got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rstp_release: got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_fips_block();
    test_nokey();
    test_stall();
    test_interleave();
    test_clr();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_block_loader.md
# aes_block_loader

Upstream feeder for the AES cipher core. Accepts a 32-bit word stream under a valid/ready handshake and assembles four key words and four data words into 4×4 byte state arrays in FIPS-197 column order. Presents each complete {data, key} block to the cipher core under a valid/ready handshake and holds it until the core accepts it.

## Interface
- `KEY_PERSIST`, default 1:
  - 1: the loaded key is retained for all following blocks.
  - 0: the key is invalidated once a block using it completes; a new key must be loaded before the next block.
- `clk` in 1: the single clock. Every register updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `clr` in 1: synchronous abort of partial key/data accumulation. Does not touch a pending output block.
- `in_word` in 32: one state column; byte r = `in_word[31-8r -: 8]`.
- `in_key` in 1: 1 = the word is a key word; 0 = the word is a data word.
- `in_valid` in 1: input word is valid.
- `in_ready` out 1: the loader can accept a word this cycle.
- `out_data` out 8 × [0:3][0:3]: data state, indexed [c][r].
- `out_key` out 8 × [0:3][0:3]: key state, indexed [c][r], captured together with the data.
- `out_valid` out 1: block is presented to the cipher core.
- `out_ready` in 1: the cipher core accepts the block.
- `err_nokey` out 1: one-cycle pulse when a data block completes with no valid key; that block is dropped.

## Operation
- A word is accepted when `in_valid && in_ready`. Key and data words use independent 2-bit column counters, `kcnt` and `dcnt`. Key and data words may interleave freely.
- Accepted key word: written to key column `kcnt`, then `kcnt` increments. When column 3 is written, `key_ok` is set and `kcnt` wraps to 0.
- Accepted data word: written to data column `dcnt`, then `dcnt` increments. When column 3 is written, `dcnt` wraps to 0 and the block completes:
  - If `key_ok` = 1: data and current key are copied to the output register and `out_valid` is set. If `KEY_PERSIST` = 0, `key_ok` is cleared.
  - If `key_ok` = 0: the block is discarded and `err_nokey` pulses.
- A key completing on the same edge as a data block does not count for that block; the block sees `key_ok` from before the edge. The new key applies from the next block.
- A key reload while a block is pending does not alter `out_key`.
- Output transfer: when `out_valid && out_ready`, `out_valid` clears, unless a new block completes on the same edge. In that case `out_valid` stays 1 and the output register takes the new block.
- `clr`: zeroes `kcnt` and `dcnt` and clears `key_ok`. `clr` takes priority over a simultaneous accept, which is dropped. `out_valid` and the output register are unaffected.

## Timing
- Values held during and after `rst`:
  - `in_ready` = 0 while `rst` is high, then 1 from the first cycle after release.
  - `out_valid`, `err_nokey` = 0.
  - `out_data`, `out_key` = all zero.
  - `kcnt`, `dcnt` = 0; `key_ok` = 0.
- Latency: 4th data word accepted at edge t → `out_valid` = 1 in cycle t+1.
- `err_nokey` is asserted in cycle t+1 only.
- `out_data`/`out_key` are stable while `out_valid` = 1 and `out_ready` = 0.
- `rst` mid-block: all partial state and any pending block are lost.
- `in_ready` depends on the build; see Configuration.

## Configuration
- `AES_LOADER_DBUF_EN` defined (double buffer):
  - Accumulation registers are separate from the output register.
  - `in_ready = !(dcnt==3 && out_valid && !out_ready)`, a combinational path from `out_ready`.
  - Sustained throughput: one block per 4 data-word cycles.
- `AES_LOADER_DBUF_EN` undefined (single buffer):
  - The output register is the accumulation register.
  - `in_ready = !out_valid`, with no combinational path from `out_ready`.
  - All accepts, key words included, stall while a block is pending.
  - Minimum 5 cycles per block.
- Handshake semantics and latency are identical in both builds.

## Structure
- Package `aes_loader_pkg`:
  - `byte_t`, `col_t` (byte [0:3]), `state_t` (col_t [0:3]).
  - `NB` = 4.
  - Function `word_to_col` (big-endian byte split).
- Sub-module `aes_col_accum`:
  - Column counter + 4-column register + completion strobe + clear.
  - Instantiated twice: key path and data path.

## Test plan
- FIPS-197 C.1 vector. Key words 00010203, 04050607, 08090a0b, 0c0d0e0f, then data 00112233 … ccddeeff, `out_ready`=1 → one `out_valid` pulse with:
  - `out_data[0]` = {00,11,22,33}
  - `out_key[3]` = {0c,0d,0e,0f}
- Data words only after reset (4 words) → `err_nokey` pulses for one cycle; `out_valid` stays 0.
- Block pending with `out_ready`=0 for 10 cycles → outputs stable.
  - DBUF build: 3 more data words accepted; `in_ready` drops before the 4th.
  - Single-buffer build: `in_ready`=0 throughout.
- Key and data words interleaved (K,D,K,D,…) → same block as the first scenario.
  - With `KEY_PERSIST`=0, a second data block without a key reload raises `err_nokey`.
- `clr` asserted after 2 data words, then 4 fresh data words → block contains only the fresh words; `key_ok` lost, so `err_nokey` pulses.
- `rst` asserted with `out_valid`=1 → next cycle `out_valid`=0 and outputs are zero.
